// File: rtl/video_pattern_gen.sv
// Test-pattern source for an AXI4-Stream video output.
// Patterns: solid colour, eight colour bars, checkerboard, horizontal grey ramp.
// Ports: aclk/aresetn/aclken are the clock, async active-low reset and clock enable.
//   enable requests frames; pattern_sel and solid_color choose the picture.
//   m_axis_video_* is the stream output (tuser = start of frame, tlast = end of line).
//   frame_cnt counts completed frames; busy is high whenever not idle.
module video_pattern_gen #(
  parameter int H_ACTIVE = 1280,
  parameter int V_ACTIVE = 720,
  parameter int H_GAP    = 16,
  parameter int V_GAP    = 64,
  parameter int CK_LOG2  = 3
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        aclken,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  input  logic [23:0] solid_color,
  input  logic        m_axis_video_tready_in,
  output logic [23:0] m_axis_video_tdata_out,
  output logic        m_axis_video_tvalid_out,
  output logic        m_axis_video_tuser_out,
  output logic        m_axis_video_tlast_out,
  output logic [15:0] frame_cnt,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_HGAP, S_VGAP} state_t;

  state_t      state_q, state_d;
  logic [11:0] x_q, x_d, y_q, y_d;
  logic [15:0] gap_q, gap_d;
  logic [15:0] fc_q, fc_d;
  logic [1:0]  pat_q, pat_d;
  logic [12:0] acc_q, acc_d;   // x*8 minus bar*H_ACTIVE, always < H_ACTIVE
  logic [2:0]  bar_q, bar_d;
  logic [23:0] tdata_q, tdata_d;
  logic        tuser_q, tuser_d, tlast_q, tlast_d;
  logic        rdone_q;        // set on the first enabled edge after reset release

  // Combinational helpers
  logic [11:0] x_n;
  logic [12:0] acc_n;
  logic [2:0]  bar_n;
  logic        start_line, frame_boundary;
  logic [11:0] line_y;
  logic [1:0]  line_pat;

  function automatic logic [23:0] pixel(input logic [1:0] pat, input logic [7:0] x8,
                                        input logic chk, input logic [2:0] bar,
                                        input logic [23:0] solid);
    pixel = 24'h000000;
    case (pat)
      2'd0: pixel = solid;
      2'd1: begin
        case (bar)
          3'd0: pixel = 24'hFFFFFF;
          3'd1: pixel = 24'hFFFF00;
          3'd2: pixel = 24'h00FFFF;
          3'd3: pixel = 24'h00FF00;
          3'd4: pixel = 24'hFF00FF;
          3'd5: pixel = 24'hFF0000;
          3'd6: pixel = 24'h0000FF;
          default: pixel = 24'h000000;
        endcase
      end
      2'd2: pixel = chk ? solid : 24'h000000;
      default: pixel = {x8, x8, x8};
    endcase
  endfunction

  always_comb begin
    state_d = state_q;  x_d = x_q;  y_d = y_q;  gap_d = gap_q;  fc_d = fc_q;
    pat_d = pat_q;  acc_d = acc_q;  bar_d = bar_q;
    tdata_d = tdata_q;  tuser_d = tuser_q;  tlast_d = tlast_q;
    start_line = 1'b0;  frame_boundary = 1'b0;
    line_y = y_q;  line_pat = pat_q;
    x_n = x_q + 12'd1;

    // Bar tracking: advance x*8 by 8 and peel off whole bar widths. Narrow
    // lines (H_ACTIVE < 8) can cross several bars per pixel, hence the loop.
    acc_n = acc_q + 13'd8;
    bar_n = bar_q;
    for (int i = 0; i < 8; i++) begin
      if (acc_n >= 13'(H_ACTIVE)) begin
        acc_n = acc_n - 13'(H_ACTIVE);
        bar_n = bar_n + 3'd1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (rdone_q && enable) begin
          start_line = 1'b1;  line_y = 12'd0;  line_pat = pattern_sel;
        end
      end
      S_ACTIVE: begin
        if (m_axis_video_tready_in) begin
          if (tlast_q) begin
            x_d = 12'd0;  tlast_d = 1'b0;  tuser_d = 1'b0;
            if (y_q != 12'(V_ACTIVE - 1)) begin
              if (H_GAP == 0) begin
                start_line = 1'b1;  line_y = y_q + 12'd1;
              end else begin
                state_d = S_HGAP;  gap_d = 16'(H_GAP);  y_d = y_q + 12'd1;
              end
            end else begin
              fc_d = fc_q + 16'd1;
              y_d  = 12'd0;
              if (V_GAP == 0) frame_boundary = 1'b1;
              else begin
                state_d = S_VGAP;  gap_d = 16'(V_GAP);
              end
            end
          end else begin
            x_d     = x_n;  acc_d = acc_n;  bar_d = bar_n;
            tdata_d = pixel(pat_q, x_n[7:0], x_n[CK_LOG2] ^ y_q[CK_LOG2], bar_n, solid_color);
            tuser_d = 1'b0;
            tlast_d = (x_n == 12'(H_ACTIVE - 1));
          end
        end
      end
      S_HGAP: begin
        if (gap_q == 16'd1) begin
          gap_d = 16'd0;  start_line = 1'b1;  line_y = y_q;
        end else begin
          gap_d = gap_q - 16'd1;
        end
      end
      default: begin // S_VGAP
        if (gap_q == 16'd1) begin
          gap_d = 16'd0;  frame_boundary = 1'b1;
        end else begin
          gap_d = gap_q - 16'd1;
        end
      end
    endcase

    // A frame boundary is the only place a run may stop or the pattern change.
    if (frame_boundary) begin
      if (enable) begin
        start_line = 1'b1;  line_y = 12'd0;  line_pat = pattern_sel;
      end else begin
        state_d = S_IDLE;
      end
    end

    // Preload the first beat of a line so tvalid rises with valid data.
    if (start_line) begin
      state_d = S_ACTIVE;  x_d = 12'd0;  y_d = line_y;  pat_d = line_pat;
      acc_d   = 13'd0;     bar_d = 3'd0;
      tdata_d = pixel(line_pat, 8'd0, line_y[CK_LOG2], 3'd0, solid_color);
      tuser_d = (line_y == 12'd0);
      tlast_d = 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= S_IDLE;  x_q <= '0;  y_q <= '0;  gap_q <= '0;  fc_q <= '0;
      pat_q <= '0;  acc_q <= '0;  bar_q <= '0;
      tdata_q <= '0;  tuser_q <= 1'b0;  tlast_q <= 1'b0;  rdone_q <= 1'b0;
    end else if (aclken) begin
      state_q <= state_d;  x_q <= x_d;  y_q <= y_d;  gap_q <= gap_d;  fc_q <= fc_d;
      pat_q <= pat_d;  acc_q <= acc_d;  bar_q <= bar_d;
      tdata_q <= tdata_d;  tuser_q <= tuser_d;  tlast_q <= tlast_d;  rdone_q <= 1'b1;
    end
  end

  assign m_axis_video_tdata_out  = tdata_q;
  assign m_axis_video_tvalid_out = (state_q == S_ACTIVE);
  assign m_axis_video_tuser_out  = tuser_q;
  assign m_axis_video_tlast_out  = tlast_q;
  assign frame_cnt               = fc_q;
  assign busy                    = (state_q != S_IDLE);

endmodule

// File: tb/tb_video_pattern_gen.sv
// Directed bench for video_pattern_gen with an 8x4 frame, gaps 2/3, 2-pixel checker.
module tb_video_pattern_gen;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        aclken = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  pattern_sel = 2'd0;
  logic [23:0] solid_color = 24'h0;
  logic        tready = 1'b1;
  logic [23:0] tdata;
  logic        tvalid, tuser, tlast, busy;
  logic [15:0] frame_cnt;

  video_pattern_gen #(.H_ACTIVE(8), .V_ACTIVE(4), .H_GAP(2), .V_GAP(3), .CK_LOG2(1)) dut (
    .aclk(aclk), .aresetn(aresetn), .aclken(aclken), .enable(enable),
    .pattern_sel(pattern_sel), .solid_color(solid_color),
    .m_axis_video_tready_in(tready),
    .m_axis_video_tdata_out(tdata), .m_axis_video_tvalid_out(tvalid),
    .m_axis_video_tuser_out(tuser), .m_axis_video_tlast_out(tlast),
    .frame_cnt(frame_cnt), .busy(busy)
  );

  always #5 aclk = ~aclk;

  int total = 0;
  int bad = 0;

  logic [23:0] cap_dat [64];
  logic        cap_usr [64];
  logic        cap_lst [64];
  int          cap_gap [64];
  int          cap_n, stall_bad, frz_bad;

  // Runs the stream until nbeats are accepted (or the cycle budget expires).
  // rnd randomises tready; drop_at clears enable once that many beats are in;
  // frz_at drops aclken for 10 cycles once that many beats are in.
  task automatic capture(input int nbeats, input bit rnd, input int drop_at, input int frz_at);
    int gapc = 0;
    bit hold = 0;
    bit frz_done = 0;
    bit r;
    logic [23:0] hd;
    logic hu, hl;
    logic [27:0] snap;
    logic [15:0] snap_fc;
    cap_n = 0; stall_bad = 0; frz_bad = 0;
    for (int cyc = 0; cyc < 3000 && cap_n < nbeats; cyc++) begin
      @(negedge aclk);
      if (frz_at >= 0 && !frz_done && cap_n == frz_at) begin
        snap = {tdata, tvalid, tuser, tlast, busy};
        snap_fc = frame_cnt;
        aclken = 1'b0;
        for (int k = 0; k < 10; k++) begin
          @(negedge aclk);
          if ({tdata, tvalid, tuser, tlast, busy} !== snap || frame_cnt !== snap_fc) frz_bad++;
        end
        aclken = 1'b1;
        frz_done = 1;
      end
      if (drop_at >= 0 && cap_n == drop_at) enable = 1'b0;
      r = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      tready = r;
      if (tvalid) begin
        if (hold && (tdata !== hd || tuser !== hu || tlast !== hl)) stall_bad++;
        if (r) begin
          cap_dat[cap_n] = tdata; cap_usr[cap_n] = tuser; cap_lst[cap_n] = tlast;
          cap_gap[cap_n] = gapc; gapc = 0; cap_n++; hold = 0;
        end else begin
          hold = 1; hd = tdata; hu = tuser; hl = tlast;
        end
      end else begin
        gapc++;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge aclk);
    aresetn = 1'b0;
    aclken = 1'b1;
    tready = 1'b1;
    @(negedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
  endtask

  task automatic test_reset();
    enable = 1'b1; pattern_sel = 2'd3;
    @(negedge aclk);
    aresetn = 1'b0;
    @(negedge aclk);
    @(negedge aclk);
    total++; if (tvalid !== 1'b0) begin bad++; $display("FAIL reset_tvalid got=%b want=0", tvalid); end
    total++; if (tdata !== 24'h0) begin bad++; $display("FAIL reset_tdata got=%h want=000000", tdata); end
    total++; if (tuser !== 1'b0 || tlast !== 1'b0) begin bad++; $display("FAIL reset_user_last got=%b%b want=00", tuser, tlast); end
    total++; if (frame_cnt !== 16'd0) begin bad++; $display("FAIL reset_frame_cnt got=%0d want=0", frame_cnt); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    aresetn = 1'b1;
    @(negedge aclk);
    total++; if (tvalid !== 1'b0) begin bad++; $display("FAIL first_edge_tvalid got=%b want=0", tvalid); end
    @(negedge aclk);
    total++; if (tvalid !== 1'b1 || tuser !== 1'b1) begin bad++; $display("FAIL second_edge_start got=%b%b want=11", tvalid, tuser); end
  endtask

  task automatic test_ramp();
    enable = 1'b1; pattern_sel = 2'd3;
    do_reset();
    capture(33, 0, -1, -1);
    total++; if (cap_n !== 33) begin bad++; $display("FAIL ramp_count got=%0d want=33", cap_n); end
    for (int b = 0; b < 32 && b < cap_n; b++) begin
      total++; if (cap_dat[b] !== 24'(24'h010101 * (b % 8))) begin bad++; $display("FAIL ramp_data beat=%0d got=%h want=%h", b, cap_dat[b], 24'(24'h010101 * (b % 8))); end
      total++; if (cap_usr[b] !== (b == 0)) begin bad++; $display("FAIL ramp_tuser beat=%0d got=%b", b, cap_usr[b]); end
      total++; if (cap_lst[b] !== (b % 8 == 7)) begin bad++; $display("FAIL ramp_tlast beat=%0d got=%b", b, cap_lst[b]); end
      if (b > 0) begin
        total++; if (cap_gap[b] !== ((b % 8 == 0) ? 2 : 0)) begin bad++; $display("FAIL ramp_gap beat=%0d got=%0d want=%0d", b, cap_gap[b], (b % 8 == 0) ? 2 : 0); end
      end
    end
    if (cap_n == 33) begin
      total++; if (cap_gap[32] !== 3 || cap_usr[32] !== 1'b1) begin bad++; $display("FAIL frame_gap got=%0d tuser=%b want=3 tuser=1", cap_gap[32], cap_usr[32]); end
    end
    @(negedge aclk);
    total++; if (frame_cnt !== 16'd1) begin bad++; $display("FAIL ramp_frame_cnt got=%0d want=1", frame_cnt); end
  endtask

  task automatic test_back_to_back();
    enable = 1'b1; pattern_sel = 2'd3;
    do_reset();
    capture(32, 1, -1, -1);
    total++; if (cap_n !== 32) begin bad++; $display("FAIL bp_count got=%0d want=32", cap_n); end
    total++; if (stall_bad !== 0) begin bad++; $display("FAIL bp_stall_hold got=%0d changes want=0", stall_bad); end
    for (int b = 0; b < cap_n; b++) begin
      total++;
      if (cap_dat[b] !== 24'(24'h010101 * (b % 8)) || cap_usr[b] !== (b == 0) || cap_lst[b] !== (b % 8 == 7)) begin
        bad++; $display("FAIL bp_beat beat=%0d got=%h/%b/%b want=%h/%b/%b", b, cap_dat[b], cap_usr[b], cap_lst[b],
                        24'(24'h010101 * (b % 8)), b == 0, b % 8 == 7);
      end
    end
  endtask

  task automatic test_bars();
    logic [23:0] exp_bar [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    enable = 1'b1; pattern_sel = 2'd1;
    do_reset();
    capture(8, 0, -1, -1);
    for (int b = 0; b < 8; b++) begin
      total++; if (cap_dat[b] !== exp_bar[b]) begin bad++; $display("FAIL bar_color x=%0d got=%h want=%h", b, cap_dat[b], exp_bar[b]); end
    end
  endtask

  task automatic test_checker();
    logic [23:0] S = 24'h123456;
    logic [23:0] exp0 [8];
    exp0 = '{24'h0, 24'h0, S, S, 24'h0, 24'h0, S, S};
    enable = 1'b1; pattern_sel = 2'd2; solid_color = S;
    do_reset();
    capture(24, 0, -1, -1);
    for (int b = 0; b < 8; b++) begin
      total++; if (cap_dat[b] !== exp0[b]) begin bad++; $display("FAIL checker_line0 x=%0d got=%h want=%h", b, cap_dat[b], exp0[b]); end
      total++; if (cap_dat[16 + b] !== (exp0[b] ^ S)) begin bad++; $display("FAIL checker_line2 x=%0d got=%h want=%h", b, cap_dat[16 + b], exp0[b] ^ S); end
    end
  endtask

  task automatic test_enable_drop();
    int hi = 0;
    int late_vld = 0;
    enable = 1'b1; pattern_sel = 2'd3;
    do_reset();
    capture(32, 0, 5, -1);
    total++; if (cap_n !== 32) begin bad++; $display("FAIL drop_count got=%0d want=32", cap_n); end
    total++; if (cap_lst[31] !== 1'b1 || cap_dat[31] !== 24'h070707) begin bad++; $display("FAIL drop_last_beat got=%h/%b want=070707/1", cap_dat[31], cap_lst[31]); end
    for (int c = 0; c < 20; c++) begin
      @(negedge aclk);
      if (tvalid) late_vld++;
      if (busy && c == hi) hi++;
    end
    total++; if (hi !== 3) begin bad++; $display("FAIL drop_busy_cycles got=%0d want=3", hi); end
    total++; if (late_vld !== 0) begin bad++; $display("FAIL drop_extra_tvalid got=%0d want=0", late_vld); end
    total++; if (frame_cnt !== 16'd1) begin bad++; $display("FAIL drop_frame_cnt got=%0d want=1", frame_cnt); end
  endtask

  task automatic test_clken();
    enable = 1'b1; pattern_sel = 2'd3;
    do_reset();
    capture(32, 0, -1, 11);
    total++; if (frz_bad !== 0) begin bad++; $display("FAIL clken_frozen got=%0d changes want=0", frz_bad); end
    total++; if (cap_n !== 32) begin bad++; $display("FAIL clken_count got=%0d want=32", cap_n); end
    for (int b = 0; b < cap_n; b++) begin
      total++; if (cap_dat[b] !== 24'(24'h010101 * (b % 8))) begin bad++; $display("FAIL clken_data beat=%0d got=%h want=%h", b, cap_dat[b], 24'(24'h010101 * (b % 8))); end
    end
  endtask

  task automatic test_reset_mid();
    enable = 1'b1; pattern_sel = 2'd3;
    do_reset();
    capture(44, 0, -1, -1);
    @(negedge aclk);
    total++; if (frame_cnt !== 16'd1 || tdata !== 24'h040404) begin bad++; $display("FAIL pre_reset got=%0d/%h want=1/040404", frame_cnt, tdata); end
    aresetn = 1'b0;
    #1;
    total++; if ({tvalid, tuser, tlast, busy} !== 4'b0000) begin bad++; $display("FAIL midreset_ctrl got=%b want=0000", {tvalid, tuser, tlast, busy}); end
    total++; if (tdata !== 24'h0 || frame_cnt !== 16'd0) begin bad++; $display("FAIL midreset_data got=%h/%0d want=000000/0", tdata, frame_cnt); end
    @(negedge aclk);
    aresetn = 1'b1;
    capture(1, 0, -1, -1);
    total++; if (cap_n !== 1 || cap_usr[0] !== 1'b1 || cap_dat[0] !== 24'h0) begin bad++; $display("FAIL restart_first got=n%0d/%b/%h want=n1/1/000000", cap_n, cap_usr[0], cap_dat[0]); end
    total++; if (frame_cnt !== 16'd0) begin bad++; $display("FAIL restart_frame_cnt got=%0d want=0", frame_cnt); end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_back_to_back();
    test_bars();
    test_checker();
    test_enable_drop();
    test_clken();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule

// File: doc/video_pattern_gen.md
VIDEO_PATTERN_GEN -- requirements
Module: video_pattern_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 1280: active pixels per line (2..4095).
REQ-002 SHALL have parameter V_ACTIVE, default 720: active lines per frame (1..4095).
REQ-003 SHALL have parameter H_GAP, default 16: idle cycles after each line's last beat (0..255).
REQ-004 SHALL have parameter V_GAP, default 64: idle cycles after each frame's last beat (0..65535).
REQ-005 SHALL have parameter CK_LOG2, default 3: checker square size is 2**CK_LOG2 pixels (0..11).
REQ-006 SHALL have port aclk, input, 1: the single clock; all logic on its rising edge.
REQ-007 SHALL have port aresetn, input, 1: reset, asynchronous and active-low.
REQ-008 SHALL have port aclken, input, 1: clock enable; when low, all state and outputs hold.
REQ-009 SHALL have port enable, input, 1: run request.
REQ-010 SHALL have port pattern_sel, input, 2: 0 solid, 1 colour bars, 2 checkerboard, 3 horizontal ramp.
REQ-011 SHALL have port solid_color, input, 24: pixel value for pattern 0 and checker "on" squares.
REQ-012 SHALL have port m_axis_video_tready_in, input, 1: downstream ready.
REQ-013 SHALL have port m_axis_video_tdata_out, output, 24: pixel.
REQ-014 SHALL have port m_axis_video_tvalid_out, output, 1: beat valid.
REQ-015 SHALL have port m_axis_video_tuser_out, output, 1: start of frame, first pixel only.
REQ-016 SHALL have port m_axis_video_tlast_out, output, 1: end of line, last pixel of each line.
REQ-017 SHALL have port frame_cnt, output, 16: completed frames, wraps 0xFFFF->0.
REQ-018 SHALL have port busy, output, 1: high in any state other than IDLE.

Function
REQ-019 SHALL implement FSM states IDLE, ACTIVE, HGAP, VGAP; all transitions require aclken high.
REQ-020 IDLE->ACTIVE when enable high; x=0, y=0; pattern_sel latched for the whole frame.
REQ-021 ACTIVE: tvalid high; beat accepted when tvalid & tready & aclken; x increments per accepted beat.
REQ-022 tdata/tuser/tlast SHALL be registered and stable while tvalid high and tready low.
REQ-023 tuser high iff x==0 and y==0; tlast high iff x==H_ACTIVE-1.
REQ-024 On an accepted tlast beat: x=0; y<V_ACTIVE-1 -> HGAP (or straight to ACTIVE if H_GAP==0) and y increments.
REQ-025 On an accepted tlast beat with y==V_ACTIVE-1: frame_cnt increments; -> VGAP (or straight on if V_GAP==0).
REQ-026 HGAP/VGAP: tvalid low for exactly H_GAP/V_GAP enabled cycles, then -> ACTIVE.
REQ-027 At VGAP end (or frame end when V_GAP==0): enable high -> ACTIVE with y=0 and pattern_sel relatched; enable low -> IDLE.
REQ-028 enable deasserted mid-frame SHALL NOT truncate the frame; stop occurs only at the frame boundary.
REQ-029 Pattern 1: 8 equal bars, bar index = (x*8)/H_ACTIVE, derived from a bar-width counter, no runtime divider.
REQ-030 Bar colours, index 0..7: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
REQ-031 Pattern 2: x[CK_LOG2]^y[CK_LOG2]==1 -> solid_color, else 000000.
REQ-032 Pattern 3: tdata = {x[7:0], x[7:0], x[7:0]}; x wraps modulo 256 visually.
REQ-033 Counters x, y SHALL be 12 bits, gap counter 16 bits; no counter overflows within the parameter ranges.
REQ-034 Each beat's tdata SHALL correspond to that beat's x/y; there is no bubble between beats of a line while tready is high.

Reset
REQ-035 aresetn low SHALL asynchronously force IDLE, x=y=0, gap counter 0, frame_cnt=0, tvalid=0, tuser=0, tlast=0, tdata=0, busy=0.
REQ-036 Reset asserted mid-frame SHALL abort without emitting tlast; after release, the first frame starts with tuser.
REQ-037 The first possible tvalid after aresetn release is on the second rising aclk edge with enable and aclken high.

Verification (H_ACTIVE=8, V_ACTIVE=4, H_GAP=2, V_GAP=3, CK_LOG2=1)
REQ-038 enable=1, tready=1, pattern 3 -> 32 beats: tdata 000000..070707 per line, tuser only on beat 0, tlast on beats 7/15/23/31, 2 idle cycles between lines, 3 before the next tuser, frame_cnt=1.
REQ-039 tready toggled randomly -> data, tuser, tlast held stable while stalled; beat sequence identical to REQ-038.
REQ-040 pattern 1 -> line pixels FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
REQ-041 pattern 2, solid_color=123456 -> line 0: 000000,000000,123456,123456,...; line 2 inverted.
REQ-042 enable dropped at beat 5 -> frame completes (32 beats), busy falls after VGAP, frame_cnt=1; aclken low for 10 cycles mid-line -> outputs frozen, no lost or duplicate beat.
REQ-043 aresetn pulsed at beat 12 -> outputs zero immediately; on restart, first beat tuser=1, tdata=000000, frame_cnt=0.
